instr_sequencer: RTL and testbench
==================================

# instr_sequencer

Multi-cycle instruction sequencer sitting ahead of the opcode decoder. It owns the program counter and fetches 39-bit instruction words from instruction memory over a req/ack handshake. It presents each word to the decoder with a one-cycle valid strobe, then gates register write-back. Opcode 3'b000 in bits [38:36] halts sequencing.

## Interface
- ADDR_W, 8, program counter / instruction address width
- INSTR_W, 39, instruction word width; opcode is bits [INSTR_W-1:INSTR_W-3]

- Clk  in  1  system clock, rising edge
- Rst  in  1  asynchronous, active-high reset
- Start  in  1  begin execution at address 0; sampled only in IDLE or HALT
- Imem_Req  out  1  fetch request, held high for the whole FETCH state
- Imem_Addr  out  ADDR_W  fetch address, equal to Pc
- Imem_Ack  in  1  memory ack; Imem_Data valid in the same cycle
- Imem_Data  in  INSTR_W  fetched instruction word
- Instr  out  INSTR_W  latched current instruction, driven to the decoder
- Instr_Valid  out  1  one-cycle pulse in EXEC
- WbEn  out  1  write-back gate, high only in WB
- Pc  out  ADDR_W  current program counter
- Busy  out  1  high in FETCH, DECODE, EXEC and WB
- Halted  out  1  high in HALT

## Operation
- States: IDLE, FETCH, DECODE, EXEC, WB, HALT.
- IDLE: waits for Start. On Start: Pc <= 0, go to FETCH.
- FETCH: Imem_Req=1 and Imem_Addr=Pc. On the edge where Imem_Ack=1, Instr <= Imem_Data and go to DECODE. With no ack, stay in FETCH indefinitely.
- DECODE: if Instr opcode == 3'b000, go to HALT; Pc is not advanced. Otherwise go to EXEC.
- EXEC: Instr_Valid=1 for exactly one cycle, then go to WB.
- WB: WbEn=1 for one cycle, Pc <= Pc+1 modulo 2^ADDR_W, then go to FETCH.
- HALT: Halted=1 and Pc holds the address of the halt word. Start goes to FETCH with Pc <= 0.
- Start is ignored in FETCH, DECODE, EXEC and WB.
- Imem_Ack is ignored outside FETCH.
- Instr changes only on a FETCH+Ack edge. It holds its value through DECODE, EXEC, WB and HALT.
- Outputs are decoded from registered state only. No combinational path from Imem_Ack to any output.

## Timing
- Reset values: state=IDLE, Pc=0, Instr=0, Imem_Req=0, Imem_Addr=0, Instr_Valid=0, WbEn=0, Busy=0, Halted=0.
- Start sampled at edge N: FETCH in cycle N+1.
- Ack in the first FETCH cycle gives these latencies:
  - DECODE at N+2
  - Instr_Valid at N+3
  - WbEn at N+4
  - next FETCH at N+5
- Minimum of 4 cycles per instruction. Each cycle of ack wait adds one cycle.
- Halt word: HALT is entered 2 cycles after its ack edge. Instr_Valid and WbEn never pulse for it.
- Pc at 2^ADDR_W-1 wraps to 0 in WB; there is no halt on wrap.
- Rst mid-operation (including FETCH with Req high) immediately forces every output to its reset value. An outstanding request is abandoned.

## Configuration
- SEQ_SINGLE_STEP_EN defined:
  - Adds input Step (1 bit) and state PAUSE.
  - WB goes to PAUSE instead of FETCH. Busy=0 in PAUSE.
  - A Step pulse in PAUSE goes to FETCH on the next edge.
  - Rst returns to IDLE from PAUSE.
  - Start is ignored in PAUSE.
- SEQ_SINGLE_STEP_EN undefined: no Step port and no PAUSE state; WB goes straight to FETCH.

## Test plan
- Reset/idle: assert Rst mid-run -> all outputs 0 in the same cycle; state IDLE after release; Start absent -> Imem_Req stays 0.
- Zero-wait stream: memory acks immediately; words opcode 001, 010, 101, then 000 -> Instr_Valid pulses at Pc 0, 1, 2, 4 cycles apart; WbEn 3 times; Halted=1 with Pc=3.
- Wait states: Ack delayed 3 cycles on address 1 -> Imem_Req held for 4 cycles with Imem_Addr=1; Instr unchanged until the ack edge; total 7 cycles for that instruction.
- Wrap: ADDR_W=2, words 0..3 nonzero, word 0 halt on second pass -> Pc sequence 0,1,2,3,0; halt on the second fetch of address 0.
- Spurious signals: Imem_Ack pulsed in EXEC and Start pulsed in WB -> no state, Pc or Instr change.
- SEQ_SINGLE_STEP_EN: after the first WB, Busy=0 and no Imem_Req for 10 cycles; Step pulse -> Imem_Req asserted the next cycle with Imem_Addr=1.

Source files
------------

// File: rtl/instr_sequencer.sv
// instr_sequencer: PC-owning fetch/decode/exec/write-back sequencer ahead of the decoder; SEQ_SINGLE_STEP_EN adds step_i and a PAUSE state
module instr_sequencer #(
  parameter int ADDR_W  = 8,
  parameter int INSTR_W = 39
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
`ifdef SEQ_SINGLE_STEP_EN
  input  logic               step_i,
`endif
  output logic               imem_req_o,
  output logic [ADDR_W-1:0]  imem_addr_o,
  input  logic               imem_ack_i,
  input  logic [INSTR_W-1:0] imem_data_i,
  output logic [INSTR_W-1:0] instr_o,
  output logic               instr_valid_o,
  output logic               wb_en_o,
  output logic [ADDR_W-1:0]  pc_o,
  output logic               busy_o,
  output logic               halted_o
);
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_WB     = 3'd4,
`ifdef SEQ_SINGLE_STEP_EN
    S_PAUSE  = 3'd6,
`endif
    S_HALT   = 3'd5
  } state_t;
  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [INSTR_W-1:0]  instr_q, instr_d;
  logic                is_halt;
  assign is_halt = instr_q[INSTR_W-1 -: 3] == 3'b000;
  // state, program counter and instruction registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      instr_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
    end
  end
  // next state: ack only matters in FETCH, start only in IDLE/HALT
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_HALT: state_d = start_i ? S_FETCH : state_q;
      S_FETCH:        state_d = imem_ack_i ? S_DECODE : S_FETCH;
      S_DECODE:       state_d = is_halt ? S_HALT : S_EXEC;
      S_EXEC:         state_d = S_WB;
`ifdef SEQ_SINGLE_STEP_EN
      S_WB:           state_d = S_PAUSE;
      S_PAUSE:        state_d = step_i ? S_FETCH : S_PAUSE;
`else
      S_WB:           state_d = S_FETCH;
`endif
      default:        state_d = S_IDLE;
    endcase
  end
  // datapath next values: restart clears pc, write-back advances it, fetch ack latches the word
  always_comb begin
    pc_d    = ((state_q == S_IDLE || state_q == S_HALT) && start_i) ? '0 :
              (state_q == S_WB) ? pc_q + 1'b1 : pc_q;
    instr_d = (state_q == S_FETCH && imem_ack_i) ? imem_data_i : instr_q;
  end
  // outputs decoded purely from registered state
  always_comb begin
    imem_req_o    = state_q == S_FETCH;
    imem_addr_o   = pc_q;
    instr_o       = instr_q;
    instr_valid_o = state_q == S_EXEC;
    wb_en_o       = state_q == S_WB;
    pc_o          = pc_q;
    busy_o        = state_q == S_FETCH || state_q == S_DECODE || state_q == S_EXEC || state_q == S_WB;
    halted_o      = state_q == S_HALT;
  end
endmodule

// File: tb/tb_instr_sequencer.sv
// tb_instr_sequencer: randomized directed bench for instr_sequencer against an instruction-level model
module tb_instr_sequencer;
  localparam int AW = 8;
  localparam int IW = 39;
  logic clk = 0, rst = 1, start = 0, ack = 0, step = 0;
  logic [IW-1:0] data = '0;
  logic req, valid, wb, busy, halted;
  logic [AW-1:0] addr, pc;
  logic [IW-1:0] instr;
  int checks = 0, errors = 0;
  logic [AW-1:0] m_pc = '0;
  logic [IW-1:0] m_instr = '0;
  bit hlt;
  instr_sequencer #(.ADDR_W(AW), .INSTR_W(IW)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start),
`ifdef SEQ_SINGLE_STEP_EN
    .step_i(step),
`endif
    .imem_req_o(req), .imem_addr_o(addr), .imem_ack_i(ack), .imem_data_i(data),
    .instr_o(instr), .instr_valid_o(valid), .wb_en_o(wb), .pc_o(pc),
    .busy_o(busy), .halted_o(halted)
  );
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  function automatic logic [IW-1:0] word(input bit halt);
    logic [2:0] op;
    logic [35:0] lo;
    op = halt ? 3'b000 : 3'($urandom_range(1, 7));
    lo = {4'($urandom), 32'($urandom)};
    return {op, lo};
  endfunction
  task automatic chk_quiet(input string tag, input bit exp_halted);
    chk({tag, "_req"}, req, 0);
    chk({tag, "_valid"}, valid, 0);
    chk({tag, "_wb"}, wb, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_halted"}, halted, exp_halted);
    chk({tag, "_pc"}, pc, m_pc);
    chk({tag, "_addr"}, addr, m_pc);
    chk({tag, "_instr"}, instr, m_instr);
  endtask
  // One instruction from its first FETCH cycle; wt = ack wait cycles, noise injects ignored start/ack
  task automatic run_instr(input logic [IW-1:0] w, input int wt, input bit noise, output bit h);
    for (int i = 0; i <= wt; i++) begin
      chk("fetch_req", req, 1);
      chk("fetch_addr", addr, m_pc);
      chk("fetch_instr", instr, m_instr);
      chk("fetch_busy", busy, 1);
      chk("fetch_valid", valid, 0);
      start = noise && $urandom_range(0, 1) == 1;
      ack = (i == wt);
      data = ack ? w : word(0);
      tick;
    end
    ack = 0;
    start = 0;
    m_instr = w;
    chk("dec_instr", instr, m_instr);
    chk("dec_req", req, 0);
    chk("dec_valid", valid, 0);
    chk("dec_wb", wb, 0);
    chk("dec_busy", busy, 1);
    if (noise) begin
      ack = 1;
      data = word(0);
      start = 1;
    end
    tick;
    ack = 0;
    start = 0;
    if (w[IW-1 -: 3] == 3'b000) begin
      chk_quiet("halt", 1);
      h = 1;
      return;
    end
    h = 0;
    chk("exec_valid", valid, 1);
    chk("exec_wb", wb, 0);
    chk("exec_pc", pc, m_pc);
    chk("exec_instr", instr, m_instr);
    if (noise) begin
      ack = 1;
      data = word(0);
    end
    tick;
    ack = 0;
    chk("wb_en", wb, 1);
    chk("wb_valid", valid, 0);
    chk("wb_pc", pc, m_pc);
    chk("wb_instr", instr, m_instr);
    start = noise;
    tick;
    start = 0;
    m_pc++;
`ifdef SEQ_SINGLE_STEP_EN
    for (int i = 0; i < ((m_pc == 1) ? 10 : $urandom_range(0, 2)); i++) begin
      chk_quiet("pause", 0);
      start = noise;
      ack = noise;
      tick;
    end
    start = 0;
    ack = 0;
    step = 1;
    tick;
    step = 0;
`endif
  endtask
  initial begin
    tick;
    tick;
    chk_quiet("reset", 0);
    rst = 0;
    for (int i = 0; i < 5; i++) begin
      ack = $urandom_range(0, 1) == 1;
      tick;
      chk_quiet("idle", 0);
    end
    ack = 0;
    // zero-wait stream 001, 010, 101, halt
    start = 1;
    tick;
    start = 0;
    m_pc = '0;
    run_instr({3'b001, 36'h123456789}, 0, 0, hlt);
    run_instr({3'b010, 36'hABCDEF012}, 0, 0, hlt);
    run_instr({3'b101, 36'h0F0F0F0F0}, 0, 0, hlt);
    run_instr({3'b000, 36'h555555555}, 0, 0, hlt);
    chk("stream_halt_pc", pc, 3);
    for (int i = 0; i < 4; i++) begin
      ack = 1;
      data = word(0);
      tick;
      chk_quiet("halt_hold", 1);
    end
    ack = 0;
    // wait states, then random waits with spurious inputs
    start = 1;
    tick;
    start = 0;
    m_pc = '0;
    run_instr(word(0), 0, 0, hlt);
    run_instr(word(0), 3, 0, hlt);
    for (int k = 0; k < 15; k++) run_instr(word(0), $urandom_range(0, 3), 1, hlt);
    // asynchronous reset while fetching
    chk("pre_rst_req", req, 1);
    rst = 1;
    #1;
    m_pc = '0;
    m_instr = '0;
    chk_quiet("midrst", 0);
    tick;
    rst = 0;
    tick;
    chk_quiet("post_rst", 0);
    // full pc wrap, then halt on the second fetch of address 0
    start = 1;
    tick;
    start = 0;
    for (int k = 0; k < (1 << AW); k++) run_instr(word(0), $urandom_range(0, 1), $urandom_range(0, 1) == 1, hlt);
    chk("wrap_pc", pc, 0);
    run_instr(word(1), $urandom_range(0, 2), 1, hlt);
    chk("wrap_halt_pc", pc, 0);
    chk("wrap_halted", halted, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
